// File: rtl/upper_stream_pkg.sv
// Shared definitions for the upper-case streaming FIFO.
//   ASCII_LOWER_A / ASCII_LOWER_Z : bounds of the lower-case letter range
//   ASCII_CASE_BIT                : offset between lower and upper case
//   entry_t                       : one FIFO word, {last, data}
package upper_stream_pkg;

  localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/toUpper.sv
// Combinational ASCII upper-case converter.
// Ports:
//   char_in  : raw byte
//   char_out : byte with 'a'..'z' mapped to 'A'..'Z'; every other value,
//              including control codes and 0x7B..0xFF, passes unchanged
module toUpper
  import upper_stream_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [7:0] char_out
);

  always_comb begin
    char_out = char_in;
    if (char_in >= ASCII_LOWER_A && char_in <= ASCII_LOWER_Z) begin
      char_out = char_in - ASCII_CASE_BIT;
    end
  end

endmodule

// File: rtl/upper_stream_fifo.sv
// Buffered streaming wrapper around toUpper: bytes accepted on a valid/ready
// input are upper-cased, stored with their framing bit in a first-word-
// fall-through FIFO and presented downstream under valid/ready.
// Optional statistics counters are built when UPPER_STREAM_STATS_EN is
// defined; otherwise conv_count/str_count are tied to zero.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake (in_ready = !full, 0 in reset)
//   in_data, in_last  : raw byte and end-of-string flag
//   out_valid/out_ready : downstream handshake (out_valid = !empty)
//   out_data, out_last  : upper-cased head byte and its framing bit
//   level             : occupancy, 0..DEPTH
//   conv_count        : accepted bytes altered by conversion (saturating)
//   str_count         : accepted bytes carrying in_last (saturating)
module upper_stream_fifo
  import upper_stream_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         conv_count,
  output logic [CNT_W-1:0]         str_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [7:0]         upper;
  entry_t             wr_entry;
  entry_t             rd_entry;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  toUpper u_to_upper (
    .char_in  (in_data),
    .char_out (upper)
  );

  // The extra pointer MSB distinguishes full from empty when the index
  // bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // No pass-through when full and no bypass when empty: push depends only
  // on full, pop only on empty.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !rst;

  assign level     = wr_ptr - rd_ptr;

  assign wr_entry  = '{last: in_last, data: upper};
  assign rd_entry  = mem[rd_ptr[AW-1:0]];
  assign out_data  = rd_entry.data;
  assign out_last  = rd_entry.last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // meaningful, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

`ifdef UPPER_STREAM_STATS_EN
  logic [CNT_W-1:0] conv_q;
  logic [CNT_W-1:0] str_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q <= '0;
      str_q  <= '0;
    end else if (push) begin
      if (upper != in_data && conv_q != '1) conv_q <= conv_q + 1'b1;
      if (in_last && str_q != '1)           str_q  <= str_q + 1'b1;
    end
  end

  assign conv_count = conv_q;
  assign str_count  = str_q;
`else
  assign conv_count = '0;
  assign str_count  = '0;
`endif

endmodule

// File: doc/upper_stream_fifo.md
# upper_stream_fifo

Buffered streaming wrapper around the existing combinational `toUpper` converter. Accepts a byte stream with valid/ready handshake and string framing (`in_last`). Upper-cases each accepted byte and stores it with its framing bit in a small first-word-fall-through FIFO. The stream is presented downstream under valid/ready, decoupling the text source from the consumer (e.g. a UART TX or display stage).

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream byte present.
- `in_ready` output 1: block can accept; `!full`.
- `in_data` input 8: raw byte.
- `in_last` input 1: byte is the final one of a string.
- `out_valid` output 1: FIFO head valid; `!empty`.
- `out_ready` input 1: downstream accepts head.
- `out_data` output 8: upper-cased byte at head.
- `out_last` output 1: framing bit of head.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `conv_count` output CNT_W: accepted bytes changed by conversion.
- `str_count` output CNT_W: accepted bytes with `in_last`=1.

## Operation
- Push occurs when `in_valid && in_ready`. The write entry is `{in_last, toUpper(in_data)}`, written at `mem[wr_ptr]`. `wr_ptr` increments.
- Conversion rule, inherited from `toUpper`:
  - 0x61..0x7A map to byte − 0x20.
  - All other values, including 0x7B..0xFF and control codes, pass unchanged.
- Pop occurs when `out_valid && out_ready`. `rd_ptr` increments.
- `out_data`/`out_last` are combinational reads of `mem[rd_ptr]` (FWFT). They are stable while `out_valid && !out_ready`.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - empty = pointers equal.
  - full = MSBs differ and the rest are equal.
  - `level` = `wr_ptr − rd_ptr`.
- Boundary behaviour:
  - Full: `in_ready`=0. Upstream holds data. No pass-through, even if a pop happens that cycle.
  - Empty: `out_valid`=0. `out_data` is don't-care. No bypass, so a byte pushed into an empty FIFO cannot be popped the same cycle.
  - Simultaneous push and pop (neither full nor empty): both happen, `level` is unchanged.
- Upstream must hold `in_data`/`in_last` while `in_valid && !in_ready`. The block does not check this.
- Counters (see Configuration):
  - Increment on push only.
  - `conv_count` increments when `toUpper(in_data) != in_data`.
  - `str_count` increments when `in_last`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (sync): pointers=0, `level`=0, `out_valid`=0, `in_ready`=1 from the first cycle after reset, counters=0. FIFO memory is not reset.
- Latency: a byte pushed at edge N appears on `out_*` with `out_valid`=1 after edge N (available to the consumer in cycle N+1).
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-stream discards all stored bytes and counts at that edge. Handshakes are ignored while `rst`=1 and `in_ready` is held 0 during reset.

## Configuration
- Macro `UPPER_STREAM_STATS_EN`.
  - Defined: counter logic is present as described.
  - Undefined: no counter registers; `conv_count` and `str_count` are tied to 0. Port list is unchanged.

## Structure
- Package `upper_stream_pkg`:
  - `ASCII_LOWER_A`=8'h61, `ASCII_LOWER_Z`=8'h7A, `ASCII_CASE_BIT`=8'h20.
  - Entry typedef: 9 bits, `{last, data}`.
- Sub-module: the existing `toUpper`, instantiated once on the write path. It must not be duplicated in this block.
- FIFO storage and pointer logic stay inline in this module.

## Test plan
- Reset, then push 'h','i'(last) → out 0x48,0x49; `out_last` only on 0x49; `str_count`=1, `conv_count`=2.
- Push 0x7B, 0xB7, 0x40, 0x5A, 0x7F → output unchanged; `conv_count` stays 0.
- With `out_ready`=0, push 9 bytes (DEPTH=8) → `in_ready` drops after the 8th, `level`=8. Release `out_ready` → all 8 drain in order, then the 9th byte.
- `in_valid`=`out_ready`=1 continuously for 100 random bytes → one pop per cycle once primed, `level` constant at 1, order preserved.
- Assert `rst` with `level`=5 → next cycle `level`=0, `out_valid`=0, counters 0.
- With macro undefined, repeat the first scenario → data identical, `conv_count`=`str_count`=0; with macro defined, force the counter to all-ones and push → value holds.
